// File: rtl/store_unit.sv
// Read-modify-write store unit: word stores write directly, byte/halfword stores
// read the containing word, merge the new lane(s) in and write the word back.
module store_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        Start,
  input  logic [1:0]  StoreSize,
  input  logic [31:0] Addr,
  input  logic [31:0] StoreData,
  input  logic [31:0] MemDataIn,
  output logic [31:0] MemAddr,
  output logic        MemWR,
  output logic [31:0] MemDataOut,
  output logic        Busy,
  output logic        Done,
  output logic        AlignErr
);

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE, ERR} state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic [15:0] data_q;
  logic [31:0] merge_q;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SZ_WORD: bad = (lo != 2'b00);
      SZ_HALF: bad = lo[0];
      SZ_BYTE: bad = 1'b0;
      default: bad = 1'b1;
    endcase
    misaligned = bad;
  endfunction

  // Little-endian lanes: byte lane k = lo, halfword lane h = lo[1].
  function automatic logic [31:0] merge_word(input logic [31:0] word, input logic [15:0] data,
                                             input logic [1:0] size, input logic [1:0] lo);
    logic [31:0] w;
    w = word;
    if (size == SZ_BYTE) begin
      case (lo)
        2'd0:    w[7:0]   = data[7:0];
        2'd1:    w[15:8]  = data[7:0];
        2'd2:    w[23:16] = data[7:0];
        default: w[31:24] = data[7:0];
      endcase
    end else if (lo[1]) begin
      w[31:16] = data;
    end else begin
      w[15:0] = data;
    end
    merge_word = w;
  endfunction

  // Address and write data are gated by registered flags so reset zeroes them at once.
  assign MemAddr    = Busy  ? {addr_q[31:2], 2'b00} : 32'd0;
  assign MemDataOut = MemWR ? merge_q : 32'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      data_q   <= '0;
      merge_q  <= '0;
      MemWR    <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      AlignErr <= 1'b0;
    end else begin
      MemWR    <= 1'b0;
      Done     <= 1'b0;
      AlignErr <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Start) begin
            addr_q <= Addr;
            size_q <= StoreSize;
            data_q <= StoreData[15:0];
            Busy   <= 1'b1;
            if (misaligned(StoreSize, Addr[1:0])) begin
              AlignErr <= 1'b1;
              state    <= ERR;
            end else if (StoreSize == SZ_WORD) begin
              merge_q <= StoreData;
              MemWR   <= 1'b1;
              state   <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        READ:  state <= WAIT;
        WAIT: begin
          merge_q <= merge_word(MemDataIn, data_q, size_q, addr_q[1:0]);
          MemWR   <= 1'b1;
          state   <= WRITE;
        end
        WRITE: begin
          Done  <= 1'b1;
          state <= DONE;
        end
        DONE, ERR: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Randomized bench for store_unit with a transaction-level reference model
// and a behavioural memory holding the expected contents.
module tb_store_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        Start;
  logic [1:0]  StoreSize;
  logic [31:0] Addr;
  logic [31:0] StoreData;
  logic [31:0] MemDataIn = 32'd0;
  logic [31:0] MemAddr;
  logic        MemWR;
  logic [31:0] MemDataOut;
  logic        Busy;
  logic        Done;
  logic        AlignErr;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_wdata;
  logic [31:0] mem [logic [31:0]];

  store_unit dut (
    .clk(clk), .reset_n(reset_n), .Start(Start), .StoreSize(StoreSize), .Addr(Addr),
    .StoreData(StoreData), .MemDataIn(MemDataIn), .MemAddr(MemAddr), .MemWR(MemWR),
    .MemDataOut(MemDataOut), .Busy(Busy), .Done(Done), .AlignErr(AlignErr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
  endfunction

  // One-cycle read latency memory
  always @(posedge clk) MemDataIn <= rd(MemAddr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Entered and left just after a negedge with the DUT idle.
  task automatic run_req(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                         input bit noise);
    bit bad;
    logic [31:0] wa, old, mask, ew, waddr;
    int sh, last, exp_w, exp_d, nw, nd, ne, wcyc, dcyc, ecyc, leak;
    logic busy_after;
    bad = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd0 && a[1:0] != 2'd0);
    wa = {a[31:2], 2'b00};
    old = rd(wa);
    if (sz == 2'd0) begin
      ew = d;
    end else begin
      if (sz == 2'd2) begin sh = 8 * int'(a[1:0]); mask = 32'hFF << sh; end
      else begin sh = 16 * int'(a[1]); mask = 32'hFFFF << sh; end
      ew = (old & ~mask) | ((d << sh) & mask);
    end
    exp_w = bad ? 0 : (sz == 2'd0 ? 1 : 3);
    exp_d = bad ? 0 : (sz == 2'd0 ? 2 : 4);
    last  = bad ? 1 : exp_d;
    nw = 0; nd = 0; ne = 0; wcyc = 0; dcyc = 0; ecyc = 0; leak = 0;
    waddr = 32'd0; last_wdata = 32'd0; busy_after = 1'bx;
    Start = 1'b1; StoreSize = sz; Addr = a; StoreData = d;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      if (cyc == 1) check("addr_c1", MemAddr, wa);
      if (MemWR) begin nw++; wcyc = cyc; waddr = MemAddr; last_wdata = MemDataOut; end
      else if (MemDataOut != 32'd0) leak++;
      if (Done) begin nd++; dcyc = cyc; end
      if (AlignErr) begin ne++; ecyc = cyc; end
      if (cyc == last + 1) busy_after = Busy;
      if (noise && cyc <= last) begin
        Start = 1'b1; StoreSize = 2'($urandom); Addr = $urandom; StoreData = $urandom;
      end else begin
        Start = 1'b0;
      end
    end
    check("n_writes", nw, bad ? 0 : 1);
    check("n_done", nd, bad ? 0 : 1);
    check("n_alignerr", ne, bad ? 1 : 0);
    check("done_cyc", dcyc, exp_d);
    check("err_cyc", ecyc, bad ? 1 : 0);
    check("busy_after", {31'd0, busy_after}, 32'd0);
    check("wdata_leak", leak, 0);
    if (!bad) begin
      check("write_cyc", wcyc, exp_w);
      check("write_addr", waddr, wa);
      check("write_data", last_wdata, ew);
      mem[wa] = ew;
    end
  endtask

  task automatic rst_mid(input int rcyc);
    int nw, nd;
    Start = 1'b1; StoreSize = 2'd2; Addr = 32'h601; StoreData = $urandom;
    for (int cyc = 1; cyc <= rcyc; cyc++) begin
      @(negedge clk);
      Start = 1'b0;
    end
    if (rcyc == 3) check("wr_before_rst", {31'd0, MemWR}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_memwr", {31'd0, MemWR}, 32'd0);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_addr", MemAddr, 32'd0);
    check("rst_wdata", MemDataOut, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    nw = 0; nd = 0;
    repeat (5) begin
      @(negedge clk);
      if (MemWR) nw++;
      if (Done) nd++;
    end
    check("post_rst_writes", nw, 0);
    check("post_rst_done", nd, 0);
    run_req(2'd0, 32'h700, $urandom, 1'b0);
  endtask

  initial begin
    Start = 1'b0; StoreSize = 2'd0; Addr = 32'd0; StoreData = 32'd0;
    #1 reset_n = 1'b0;
    #1;
    check("reset_memwr", {31'd0, MemWR}, 32'd0);
    check("reset_addr", MemAddr, 32'd0);
    check("reset_wdata", MemDataOut, 32'd0);
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_flags", {30'd0, Done, AlignErr}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    mem[32'h200] = 32'h11223344;
    mem[32'h300] = 32'h11223344;
    run_req(2'd0, 32'h100, 32'hDEADBEEF, 1'b0);
    check("sw_example", last_wdata, 32'hDEADBEEF);
    run_req(2'd2, 32'h203, 32'h000000AB, 1'b0);
    check("sb_example", last_wdata, 32'hAB223344);
    run_req(2'd1, 32'h302, 32'h0000CAFE, 1'b0);
    check("sh_example", last_wdata, 32'hCAFE3344);
    run_req(2'd1, 32'h401, $urandom, 1'b0);
    run_req(2'd0, 32'h402, $urandom, 1'b0);
    run_req(2'd3, 32'h404, $urandom, 1'b0);
    run_req(2'd2, 32'h500, 32'h0000005A, 1'b1);

    rst_mid(2);
    rst_mid(3);

    for (int i = 0; i < 60; i++)
      run_req(2'($urandom), 32'h1000 | ($urandom & 32'h3F), $urandom, bit'($urandom_range(1, 0)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 reset_n  in  1  asynchronous, active-low reset; clears all state immediately on assertion.
REQ-003 Start  in  1  store request; sampled only in IDLE.
REQ-004 StoreSize  in  2  00=word (sw), 01=halfword (sh), 10=byte (sb), 11=illegal; sampled with Start.
REQ-005 Addr  in  32  byte address of the store; sampled with Start.
REQ-006 StoreData  in  32  register data to store (rt); sampled with Start; byte uses [7:0], halfword uses [15:0].
REQ-007 MemDataIn  in  32  memory read data; valid the cycle after a read address is presented (1-cycle read latency).
REQ-008 MemAddr  out  32  word address to memory, always {addr[31:2],2'b00} while Busy; 0 in IDLE.
REQ-009 MemWR  out  1  1 = write MemDataOut to MemAddr this cycle; 0 = read.
REQ-010 MemDataOut  out  32  word written to memory; 0 whenever MemWR=0.
REQ-011 Busy  out  1  1 in every state except IDLE.
REQ-012 Done  out  1  one-cycle pulse on completion of a valid store.
REQ-013 AlignErr  out  1  one-cycle pulse on a rejected request; no memory write occurs.

Function
REQ-014 The block SHALL implement states IDLE, READ, WAIT, WRITE, DONE, ERR, registered and one-hot or binary at implementer's choice.
REQ-015 In IDLE with Start=1 the block SHALL latch Addr, StoreSize and StoreData into internal registers.
REQ-016 Misaligned request SHALL go IDLE->ERR: StoreSize=11; halfword with Addr[0]=1; word with Addr[1:0]!=00.
REQ-017 Valid word request SHALL go IDLE->WRITE (no read phase); valid byte/halfword SHALL go IDLE->READ.
REQ-018 READ: MemWR=0, MemAddr=word address, one cycle, then WAIT.
REQ-019 WAIT: MemDataIn SHALL be captured into a merge register, one cycle, then WRITE.
REQ-020 Merge, little-endian lanes: byte replaces bits [8k+7:8k], k=addr[1:0]; halfword replaces [16h+15:16h], h=addr[1]; all other bits come from the captured word unchanged.
REQ-021 WRITE: MemWR=1 for exactly one cycle, MemDataOut = merged word (byte/half) or latched StoreData (word), then DONE.
REQ-022 DONE: Done=1 for one cycle, then IDLE; ERR: AlignErr=1 for one cycle, then IDLE.
REQ-023 Latency from Start cycle (cycle 0): word Done at cycle 2; byte/halfword Done at cycle 4; error AlignErr at cycle 1.
REQ-024 Start while Busy SHALL be ignored; inputs changing while Busy SHALL not affect the operation in progress.
REQ-025 Start asserted in the DONE/ERR cycle SHALL be ignored; a new request is accepted only from IDLE (earliest the cycle after DONE/ERR).
REQ-026 Exactly one MemWR=1 cycle per valid request; zero for a rejected request.

Reset
REQ-027 On reset_n=0 the block SHALL enter IDLE and drive MemWR=0, MemAddr=0, MemDataOut=0, Busy=0, Done=0, AlignErr=0, and clear latched registers, asynchronously.
REQ-028 Reset asserted mid-operation (including in WRITE) SHALL deassert MemWR immediately; the aborted store SHALL produce no Done and no later write.
REQ-029 After reset_n rises, the first rising edge with Start=1 in IDLE SHALL start a new request normally.

Verification
REQ-030 sw: Addr=0x100, StoreData=0xDEADBEEF -> cycle 1 MemWR=1, MemAddr=0x100, MemDataOut=0xDEADBEEF; cycle 2 Done=1; no read cycle.
REQ-031 sb: Addr=0x203, StoreData=0x000000AB, memory word 0x11223344 -> cycle 1 read at 0x200; cycle 3 write 0xAB223344; cycle 4 Done=1.
REQ-032 sh: Addr=0x302, StoreData=0x0000CAFE, memory word 0x11223344 -> cycle 3 write 0xCAFE3344 at 0x300; Done cycle 4.
REQ-033 Misaligned: sh at 0x401, sw at 0x402, StoreSize=11 -> each AlignErr=1 at cycle 1, MemWR never 1, Done never 1.
REQ-034 Start pulsed every cycle during an sb at 0x500 -> only one write, at cycle 3; next request accepted only after Done cycle.
REQ-035 reset_n=0 during WAIT of an sb -> MemWR, Busy, MemAddr at 0 immediately; no write or Done afterwards; next sw after release completes in 2 cycles.
